// File: rtl/param_acc_cpu.sv
// rtl/param_acc_cpu.sv - parametrised two-cycle accumulator CPU with parallel program/data load ports
module param_acc_cpu #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Load_addr,
   input  logic              Imem_we,
   input  logic [ADDR_W+2:0] Imem_wdata,
   input  logic              Dmem_we,
   input  logic [DATA_W-1:0] Dmem_wdata,
   output logic [ADDR_W+2:0] Instruction,
   output logic [DATA_W-1:0] Data_mem,
   output logic [DATA_W-1:0] Acc,
   output logic [ADDR_W-1:0] Pc,
   output logic              Zero,
   output logic              Carry,
   output logic              Busy,
   output logic              Halted
);
   localparam int INSTR_W = ADDR_W + 3;
   localparam int DEPTH   = 2 ** ADDR_W;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_ir;
   logic [DATA_W-1:0]   r_acc;
   logic                r_carry;
   logic                r_busy;
   logic                r_halted;
   logic [INSTR_W-1:0]  r_imem [DEPTH];
   logic [DATA_W-1:0]   r_dmem [DEPTH];

   logic                w_loadable;
   logic [2:0]          w_op;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_operand;
   logic [DATA_W:0]     w_sum;
   logic                w_zero;
   logic [ADDR_W-1:0]   w_pc_inc1;
   logic [ADDR_W-1:0]   w_pc_inc2;

   assign w_loadable = (r_state == S_IDLE) || (r_state == S_HALT);
   assign w_op       = r_ir[INSTR_W-1 -: 3];
   assign w_addr     = r_ir[ADDR_W-1:0];
   assign w_operand  = r_dmem[w_addr];
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_operand};
   assign w_zero     = (r_acc == '0);
   // Pc arithmetic is ADDR_W wide, so wrap modulo DEPTH falls out for free.
   assign w_pc_inc1  = r_pc + ADDR_W'(1);
   assign w_pc_inc2  = r_pc + ADDR_W'(2);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_ir     <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         if (w_loadable && Imem_we) r_imem[Load_addr] <= Imem_wdata;
         if (w_loadable && Dmem_we) r_dmem[Load_addr] <= Dmem_wdata;
         case (r_state)
            S_IDLE, S_HALT: begin
               if (Start) begin
                  r_state  <= S_FETCH;
                  r_pc     <= '0;
                  r_acc    <= '0;
                  r_carry  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            S_FETCH: begin
               r_ir    <= r_imem[r_pc];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_state <= S_FETCH;
               r_pc    <= w_pc_inc1;
               case (w_op)
                  OP_HLT: begin
                     r_pc     <= r_pc;
                     r_state  <= S_HALT;
                     r_busy   <= 1'b0;
                     r_halted <= 1'b1;
                  end
                  OP_SKZ: r_pc <= w_zero ? w_pc_inc2 : w_pc_inc1;
                  OP_ADD: {r_carry, r_acc} <= w_sum;
                  OP_AND: begin
                     r_acc   <= r_acc & w_operand;
                     r_carry <= 1'b0;
                  end
                  OP_XOR: begin
                     r_acc   <= r_acc ^ w_operand;
                     r_carry <= 1'b0;
                  end
                  OP_LDA: r_acc <= w_operand;
                  OP_STO: r_dmem[w_addr] <= r_acc;
                  OP_JMP: r_pc <= w_addr;
                  default: r_pc <= w_pc_inc1;
               endcase
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Instruction = r_ir;
   assign Data_mem    = w_operand;
   assign Acc         = r_acc;
   assign Pc          = r_pc;
   assign Zero        = w_zero;
   assign Carry       = r_carry;
   assign Busy        = r_busy;
   assign Halted      = r_halted;
endmodule

// File: tb/tb_param_acc_cpu.sv
// tb/tb_param_acc_cpu.sv - bench for param_acc_cpu against an instruction-level reference model
module tb_param_acc_cpu;
   logic       Clk, Reset;
   logic       Start, Imem_we, Dmem_we;
   logic [4:0] Load_addr;
   logic [7:0] Imem_wdata, Dmem_wdata;
   logic [7:0] Instruction, Data_mem, Acc;
   logic [4:0] Pc;
   logic       Zero, Carry, Busy, Halted;

   logic        x_start, x_imem_we, x_dmem_we;
   logic [5:0]  x_load_addr;
   logic [8:0]  x_imem_wdata, x_instruction;
   logic [15:0] x_dmem_wdata, x_data_mem, x_acc;
   logic [5:0]  x_pc;
   logic        x_zero, x_carry, x_busy, x_halted;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_imem [32];
   logic [7:0] m_dmem [32];

   param_acc_cpu dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Load_addr(Load_addr),
      .Imem_we(Imem_we), .Imem_wdata(Imem_wdata), .Dmem_we(Dmem_we), .Dmem_wdata(Dmem_wdata),
      .Instruction(Instruction), .Data_mem(Data_mem), .Acc(Acc), .Pc(Pc),
      .Zero(Zero), .Carry(Carry), .Busy(Busy), .Halted(Halted)
   );

   param_acc_cpu #(.DATA_W(16), .ADDR_W(6)) dut_wide (
      .Clk(Clk), .Reset(Reset), .Start(x_start), .Load_addr(x_load_addr),
      .Imem_we(x_imem_we), .Imem_wdata(x_imem_wdata), .Dmem_we(x_dmem_we), .Dmem_wdata(x_dmem_wdata),
      .Instruction(x_instruction), .Data_mem(x_data_mem), .Acc(x_acc), .Pc(x_pc),
      .Zero(x_zero), .Carry(x_carry), .Busy(x_busy), .Halted(x_halted)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic load_i(input logic [4:0] a, input logic [7:0] d);
      Load_addr = a; Imem_wdata = d; Imem_we = 1'b1;
      tick();
      Imem_we = 1'b0;
      m_imem[a] = d;
   endtask

   task automatic load_d(input logic [4:0] a, input logic [7:0] d);
      Load_addr = a; Dmem_wdata = d; Dmem_we = 1'b1;
      tick();
      Dmem_we = 1'b0;
      m_dmem[a] = d;
   endtask

   task automatic pulse_start;
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic do_reset;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   // Edges counted after the Start edge until Halted is seen, or max if it never is.
   task automatic wait_halt(input int max, output int n);
      n = 0;
      while (!Halted && n < max) begin
         tick();
         n++;
      end
   endtask

   // A HLT word carrying an address makes Data_mem show that dmem word once halted.
   task automatic peek(input logic [4:0] a, output logic [7:0] d);
      int n;
      load_i(5'd0, {3'b000, a});
      pulse_start();
      wait_halt(10, n);
      d = Data_mem;
   endtask

   // Executes the program held in m_imem/m_dmem one instruction at a time.
   task automatic run_model(input int max_i, output logic [7:0] acc, output logic c,
                            output logic [4:0] pc, output bit hl, output int n);
      logic [7:0] ir;
      logic [4:0] a;
      int sum;
      acc = 8'h00; c = 1'b0; pc = 5'd0; hl = 1'b0; n = 0;
      while (!hl && n < max_i) begin
         ir = m_imem[pc];
         a  = ir[4:0];
         n++;
         case (ir[7:5])
            3'd0: hl = 1'b1;
            3'd1: pc = pc + ((acc == 8'h00) ? 5'd2 : 5'd1);
            3'd2: begin
               sum = int'(acc) + int'(m_dmem[a]);
               c = (sum > 255); acc = 8'(sum); pc = pc + 5'd1;
            end
            3'd3: begin acc = acc & m_dmem[a]; c = 1'b0; pc = pc + 5'd1; end
            3'd4: begin acc = acc ^ m_dmem[a]; c = 1'b0; pc = pc + 5'd1; end
            3'd5: begin acc = m_dmem[a]; pc = pc + 5'd1; end
            3'd6: begin m_dmem[a] = acc; pc = pc + 5'd1; end
            default: pc = a;
         endcase
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      checks++; if (Pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %h want 0", Pc); end
      checks++; if (Acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 0", Acc); end
      checks++; if (Instruction !== 8'h00) begin errors++; $display("FAIL reset_ir got %h want 0", Instruction); end
      checks++; if ({Carry, Busy, Halted, Zero} !== 4'b0001) begin errors++; $display("FAIL reset_flags got %b want 0001", {Carry, Busy, Halted, Zero}); end
      checks++; if ({x_busy, x_halted, x_acc, x_pc} !== 24'h0) begin errors++; $display("FAIL reset_wide got %h want 0", {x_busy, x_halted, x_acc, x_pc}); end
   endtask

   task automatic test_basic;
      int n;
      logic [7:0] d;
      load_d(5'd10, 8'h7F);
      load_d(5'd11, 8'h81);
      load_i(5'd0, 8'hAA); load_i(5'd1, 8'h4B); load_i(5'd2, 8'hCC); load_i(5'd3, 8'h00);
      pulse_start();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", Busy); end
      wait_halt(40, n);
      checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", n); end
      checks++; if (Acc !== 8'h00 || Carry !== 1'b1 || Zero !== 1'b1) begin errors++; $display("FAIL basic_result got acc %h c %b z %b want 00 1 1", Acc, Carry, Zero); end
      checks++; if (Pc !== 5'd3 || Busy !== 1'b0) begin errors++; $display("FAIL basic_pc got %0d busy %b want 3 0", Pc, Busy); end
      peek(5'd12, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_sto got %h want 00", d); end
   endtask

   task automatic test_back_to_back;
      int n;
      load_i(5'd0, 8'hAA);
      pulse_start();
      tick(); tick();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_halt(40, n);
      checks++; if (n + 3 != 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", n + 3); end
      checks++; if (Acc !== 8'h00 || Carry !== 1'b1) begin errors++; $display("FAIL b2b_result got %h %b want 00 1", Acc, Carry); end
   endtask

   task automatic test_skz;
      int n;
      load_d(5'd1, 8'h00);
      load_i(5'd0, 8'hA1); load_i(5'd1, 8'h20); load_i(5'd2, 8'hE0); load_i(5'd3, 8'h00);
      pulse_start();
      wait_halt(40, n);
      checks++; if (Halted !== 1'b1 || Pc !== 5'd3 || n != 6) begin errors++; $display("FAIL skz_taken got halted %b pc %0d cyc %0d want 1 3 6", Halted, Pc, n); end
   endtask

   task automatic test_loop;
      bit stuck;
      load_d(5'd1, 8'h05);
      pulse_start();
      stuck = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Busy !== 1'b1 || Halted !== 1'b0) stuck = 1'b0;
      end
      checks++; if (!stuck) begin errors++; $display("FAIL skz_loop got halted %b busy %b want 0 1", Halted, Busy); end
      do_reset();
   endtask

   task automatic test_wrap;
      int n;
      bit wrapped, hl;
      logic [4:0] prev, epc;
      logic [7:0] eacc;
      logic ec;
      int en;
      load_d(5'd2, 8'h33);
      load_i(5'd0, 8'h20); load_i(5'd1, 8'h00); load_i(5'd2, 8'hE5);
      load_i(5'd5, 8'hFF); load_i(5'd31, 8'hA2);
      run_model(40, eacc, ec, epc, hl, en);
      pulse_start();
      n = 0; wrapped = 1'b0; prev = Pc;
      while (!Halted && n < 60) begin
         tick();
         n++;
         if (prev == 5'd31 && Pc == 5'd0) wrapped = 1'b1;
         prev = Pc;
      end
      checks++; if (!wrapped) begin errors++; $display("FAIL wrap_pc got no 31->0 step want 31->0"); end
      checks++; if (Pc !== epc || Acc !== eacc || n != 2 * en) begin errors++; $display("FAIL wrap_end got pc %0d acc %h cyc %0d want %0d %h %0d", Pc, Acc, n, epc, eacc, 2 * en); end
   endtask

   task automatic test_reset_sto;
      logic [7:0] d;
      load_d(5'd10, 8'h55); load_d(5'd12, 8'hA5);
      load_i(5'd0, 8'hAA); load_i(5'd1, 8'hCC); load_i(5'd2, 8'h00);
      pulse_start();
      tick(); tick(); tick();
      checks++; if (Instruction !== 8'hCC || Acc !== 8'h55) begin errors++; $display("FAIL rst_pre got ir %h acc %h want CC 55", Instruction, Acc); end
      do_reset();
      checks++; if (Pc !== 5'd0 || Acc !== 8'h00 || Busy !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL rst_abort got pc %0d acc %h busy %b halted %b want 0 00 0 0", Pc, Acc, Busy, Halted); end
      peek(5'd12, d);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rst_sto got %h want A5", d); end
   endtask

   task automatic test_random;
      int n, en;
      bit hl;
      logic [4:0] epc, a;
      logic [7:0] eacc, d;
      logic ec;
      for (int it = 0; it < 12; it++) begin
         for (int k = 0; k < 32; k++) begin
            Load_addr = 5'(k);
            Imem_wdata = 8'($urandom); Dmem_wdata = 8'($urandom);
            Imem_we = 1'b1; Dmem_we = 1'b1;
            tick();
            Imem_we = 1'b0; Dmem_we = 1'b0;
            m_imem[k] = Imem_wdata; m_dmem[k] = Dmem_wdata;
         end
         run_model(40, eacc, ec, epc, hl, en);
         pulse_start();
         if (hl) begin
            wait_halt(100, n);
            checks++; if (n != 2 * en) begin errors++; $display("FAIL rand_cycles it %0d got %0d want %0d", it, n, 2 * en); end
            checks++; if (Acc !== eacc || Carry !== ec || Zero !== (eacc == 8'h00)) begin errors++; $display("FAIL rand_acc it %0d got %h c %b z %b want %h %b", it, Acc, Carry, Zero, eacc, ec); end
            checks++; if (Pc !== epc) begin errors++; $display("FAIL rand_pc it %0d got %0d want %0d", it, Pc, epc); end
            a = 5'($urandom_range(1, 31));
            peek(a, d);
            checks++; if (d !== m_dmem[a]) begin errors++; $display("FAIL rand_dmem it %0d addr %0d got %h want %h", it, a, d, m_dmem[a]); end
         end else begin
            repeat (80) tick();
            checks++; if (Busy !== 1'b1 || Halted !== 1'b0) begin errors++; $display("FAIL rand_run it %0d got busy %b halted %b want 1 0", it, Busy, Halted); end
            do_reset();
         end
      end
   endtask

   task automatic test_wide;
      int n;
      x_load_addr = 6'd0; x_imem_wdata = 9'h140; x_dmem_wdata = 16'hFFFF;
      x_imem_we = 1'b1; x_dmem_we = 1'b1;
      tick();
      x_load_addr = 6'd1; x_imem_wdata = 9'h081; x_dmem_wdata = 16'h0001;
      tick();
      x_dmem_we = 1'b0;
      x_load_addr = 6'd2; x_imem_wdata = 9'h000;
      tick();
      x_imem_we = 1'b0;
      x_start = 1'b1;
      tick();
      x_start = 1'b0;
      // Writes attempted mid-run would turn HLT into JMP 0 and zero the addend.
      x_load_addr = 6'd2; x_imem_wdata = 9'h1C0; x_imem_we = 1'b1;
      tick();
      x_imem_we = 1'b0;
      x_load_addr = 6'd1; x_dmem_wdata = 16'h0000; x_dmem_we = 1'b1;
      tick();
      x_dmem_we = 1'b0;
      n = 2;
      while (!x_halted && n < 40) begin
         tick();
         n++;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL wide_latency got %0d want 6", n); end
      checks++; if (x_acc !== 16'h0000 || x_carry !== 1'b1 || x_zero !== 1'b1) begin errors++; $display("FAIL wide_add got %h c %b z %b want 0000 1 1", x_acc, x_carry, x_zero); end
      checks++; if (x_pc !== 6'd2 || x_instruction !== 9'h000) begin errors++; $display("FAIL wide_busy_load got pc %0d ir %h want 2 000", x_pc, x_instruction); end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Imem_we = 1'b0; Dmem_we = 1'b0;
      Load_addr = '0; Imem_wdata = '0; Dmem_wdata = '0;
      x_start = 1'b0; x_imem_we = 1'b0; x_dmem_we = 1'b0;
      x_load_addr = '0; x_imem_wdata = '0; x_dmem_wdata = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_skz();
      test_loop();
      test_wrap();
      test_reset_sto();
      test_random();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
